// File: rtl/snes_pad_responder.sv
// Console-side controller-port responder: latches the active-low button vector on
// pad_latch and shifts it out LSB-first on pad_data, one bit per pad_clk rising edge.
module snes_pad_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] buttons_n,
    input  logic        pad_latch,
    input  logic        pad_clk,
    output logic        pad_data,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  bit_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCHED  = 2'd1,
        SHIFTING = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic                   latch_prev_q, latch_prev_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   latch_rise_q, latch_rise_d;
    logic                   latch_fall_q, latch_fall_d;
    logic                   clk_rise_q, clk_rise_d;
    logic [15:0]            sr_q, sr_d;
    logic [4:0]             bit_count_q, bit_count_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   pad_data_q, pad_data_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   latch_s, clk_s;

    assign latch_s = latch_sync_q[SYNC_STAGES-1];
    assign clk_s   = clk_sync_q[SYNC_STAGES-1];

    // Synchronizers feed registered strobes, so pin edge to strobe is SYNC_STAGES+1 cycles.
    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad_latch};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
        latch_prev_d = latch_s;
        clk_prev_d   = clk_s;
        latch_rise_d = latch_s & ~latch_prev_q;
        latch_fall_d = ~latch_s & latch_prev_q;
        clk_rise_d   = clk_s & ~clk_prev_q;
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_count_d  = bit_count_q;
        tmo_d        = '0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                sr_d        = 16'hFFFF;
                bit_count_d = 5'd0;
                if (latch_rise_q) begin
                    state_d = LATCHED;
                end
            end

            LATCHED: begin
                if (latch_s) begin
                    sr_d = buttons_n;
                end
                if (latch_fall_q) begin
                    state_d     = SHIFTING;
                    bit_count_d = 5'd0;
                end
            end

            SHIFTING: begin
                // A new latch always wins over a coincident shift edge.
                if (latch_rise_q) begin
                    state_d = LATCHED;
                end else if (clk_rise_q) begin
                    sr_d = {1'b1, sr_q[15:1]};
                    if (bit_count_q != 5'd31) begin
                        bit_count_d = bit_count_q + 5'd1;
                    end
                    frame_done_d = (bit_count_q == 5'd15);
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    sr_d        = 16'hFFFF;
                    bit_count_d = 5'd0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d     = IDLE;
                sr_d        = 16'hFFFF;
                bit_count_d = 5'd0;
            end
        endcase

        pad_data_d = sr_d[0];
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b0;
            latch_rise_q <= 1'b0;
            latch_fall_q <= 1'b0;
            clk_rise_q   <= 1'b0;
            sr_q         <= 16'hFFFF;
            bit_count_q  <= 5'd0;
            tmo_q        <= '0;
            pad_data_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
            latch_prev_q <= latch_prev_d;
            clk_prev_q   <= clk_prev_d;
            latch_rise_q <= latch_rise_d;
            latch_fall_q <= latch_fall_d;
            clk_rise_q   <= clk_rise_d;
            sr_q         <= sr_d;
            bit_count_q  <= bit_count_d;
            tmo_q        <= tmo_d;
            pad_data_q   <= pad_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pad_data   = pad_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign bit_count  = bit_count_q;

endmodule
